// File: rtl/t_ff_rx_if.sv
// Event-side bundle of the toggle-link receiver: handshake, status counters and sticky overflow.
interface t_ff_rx_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int PW = $clog2(DEPTH + 1);

  logic          evt_valid;
  logic          evt_ready;
  logic          ack_q;
  logic [PW-1:0] pend_cnt;
  logic [CNT_W-1:0] evt_cnt;
  logic          ovf;
  logic          clr_ovf;

  modport master (
    output evt_valid, ack_q, pend_cnt, evt_cnt, ovf,
    input  evt_ready, clr_ovf
  );

  modport slave (
    input  evt_valid, ack_q, pend_cnt, evt_cnt, ovf,
    output evt_ready, clr_ovf
  );
endinterface

// File: rtl/t_ff_rx.sv
// Toggle-link receiver: synchronizes din_t, turns each level change into a pending event,
// hands events out over ready/valid and returns a toggle acknowledge per consumed event.
module t_ff_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       din_t,
  t_ff_rx_if.master  evt
);
  localparam int PW = $clog2(DEPTH + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             init_cnt, init_cnt_nxt;
  logic [SYNC_STAGES-1:0] stage;
  logic                   sync_q;
  logic                   prev;
  logic                   det;
  logic                   acc;
  logic                   full;
  logic                   drop;
  logic                   keep;
  logic [PW-1:0]          pend;
  logic [CNT_W-1:0]       cnt;
  logic                   ack;
  logic                   ovf_r;

  assign sync_q = stage[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stage <= '0;
      prev  <= 1'b0;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], din_t};
      prev  <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // INIT lasts one edge beyond the chain depth so prev has caught up with sync_q
  // before detection starts; a level held high through reset is then not an event.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    det          = 1'b0;
    case (state)
      INIT: begin
        if (init_cnt == 3'(SYNC_STAGES)) state_nxt = RUN;
        else                             init_cnt_nxt = init_cnt + 3'd1;
      end
      RUN:     det = sync_q ^ prev;
      default: state_nxt = INIT;
    endcase
  end

  assign acc  = (pend != '0) & evt.evt_ready;
  assign full = (pend == PW'(DEPTH));
  assign drop = det & ~acc & full;
  assign keep = det & ~drop;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend  <= '0;
      cnt   <= '0;
      ack   <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      if (keep & ~acc)     pend <= pend + PW'(1);
      else if (~det & acc) pend <= pend - PW'(1);
      cnt <= cnt + CNT_W'(keep);
      ack <= ack ^ acc;
      if (drop)             ovf_r <= 1'b1;
      else if (evt.clr_ovf) ovf_r <= 1'b0;
    end
  end

  assign evt.evt_valid = (pend != '0);
  assign evt.pend_cnt  = pend;
  assign evt.evt_cnt   = cnt;
  assign evt.ack_q     = ack;
  assign evt.ovf       = ovf_r;
endmodule
